// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with direct-decode and timed scan modes.
// Optional build macro DECODER_ACTIVE_LOW_OUT_EN inverts out at its register (idle/reset = all-ones).
module decoder_n_scan #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [SEL_W-1:0]      in,
    input  logic                  en_in,
    input  logic                  mode_in,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      idx_out,
    output logic                  wrap_out
);

    localparam int N  = 2 ** SEL_W;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]    DWELL_LAST = CW'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_MAX    = '1;

`ifdef DECODER_ACTIVE_LOW_OUT_EN
    localparam logic [N-1:0] OUT_IDLE = '1;
`else
    localparam logic [N-1:0] OUT_IDLE = '0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q,   idx_d;
    logic [CW-1:0]    dwell_q, dwell_d;
    logic [N-1:0]     out_q,   out_d;
    logic             wrap_q,  wrap_d;

    // One-hot pattern for an index, already in the output polarity of this build.
    function automatic logic [N-1:0] drive(input logic [SEL_W-1:0] i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
`ifdef DECODER_ACTIVE_LOW_OUT_EN
        return ~r;
`else
        return r;
`endif
    endfunction

    // Next-state and next-output logic; state choice depends only on en_in/mode_in.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        out_d   = out_q;
        wrap_d  = 1'b0;
        if (!en_in) begin
            state_d = IDLE;
            dwell_d = '0;
            out_d   = OUT_IDLE;
        end else if (!mode_in) begin
            state_d = DIRECT;
            idx_d   = in;
            dwell_d = '0;
            out_d   = drive(in);
        end else if (state_q != SCAN) begin
            // Any entry into scan restarts from the supplied index; there is no resume.
            state_d = SCAN;
            idx_d   = in;
            dwell_d = '0;
            out_d   = drive(in);
        end else if (dwell_q == DWELL_LAST) begin
            state_d = SCAN;
            dwell_d = '0;
            idx_d   = idx_q + SEL_W'(1);
            out_d   = drive(idx_q + SEL_W'(1));
            wrap_d  = (idx_q == IDX_MAX);
        end else begin
            state_d = SCAN;
            dwell_d = dwell_q + CW'(1);
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            out_q   <= OUT_IDLE;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out      = out_q;
    assign idx_out  = idx_q;
    assign wrap_out = wrap_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Bench for decoder_n_scan: two instances (SEL_W=2/DWELL=3 and SEL_W=3/DWELL=1) against a time-based model.
module tb_decoder_n_scan;

`ifdef DECODER_ACTIVE_LOW_OUT_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif

    localparam int MW [2] = '{2, 3};
    localparam int MD [2] = '{3, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] din;
    logic       chk_en = 1'b0;

    logic [3:0] o2;
    logic [1:0] i2;
    logic       w2;
    logic [7:0] o3;
    logic [2:0] i3;
    logic       w3;

    int tests = 0;
    int fails = 0;

    // Model: position is derived from entry index plus elapsed scan cycles.
    bit m_act  [2];
    bit m_scan [2];
    int m_idx  [2];
    int m_s    [2];
    int m_t    [2];

    decoder_n_scan #(.SEL_W(2), .DWELL(3)) u_dut2 (
        .clk_in(clk), .rst_n_in(rst_n), .in(din[1:0]), .en_in(en), .mode_in(mode),
        .out(o2), .idx_out(i2), .wrap_out(w2)
    );

    decoder_n_scan #(.SEL_W(3), .DWELL(1)) u_dut3 (
        .clk_in(clk), .rst_n_in(rst_n), .in(din), .en_in(en), .mode_in(mode),
        .out(o3), .idx_out(i3), .wrap_out(w3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pol4(input logic [3:0] x);
        return AL ? ~x : x;
    endfunction

    function automatic logic [7:0] pol8(input logic [7:0] x);
        return AL ? ~x : x;
    endfunction

    function automatic logic [31:0] exp_out(input int k);
        logic [31:0] v;
        int n;
        n = 1 << MW[k];
        v = m_act[k] ? (32'd1 << m_idx[k]) : 32'd0;
        if (AL) v = ~v & ((32'd1 << n) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] exp_wrap(input int k);
        return (m_scan[k] && m_t[k] > 0 && (m_t[k] % MD[k]) == 0 && m_idx[k] == 0) ? 32'd1 : 32'd0;
    endfunction

    // Reference model update.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_act[k]  <= 1'b0;
                m_scan[k] <= 1'b0;
                m_idx[k]  <= 0;
                m_t[k]    <= 0;
                m_s[k]    <= 0;
            end else if (!en) begin
                m_act[k]  <= 1'b0;
                m_scan[k] <= 1'b0;
            end else if (!mode) begin
                m_act[k]  <= 1'b1;
                m_scan[k] <= 1'b0;
                m_idx[k]  <= int'(din) % (1 << MW[k]);
            end else if (!m_scan[k]) begin
                m_act[k]  <= 1'b1;
                m_scan[k] <= 1'b1;
                m_s[k]    <= int'(din) % (1 << MW[k]);
                m_idx[k]  <= int'(din) % (1 << MW[k]);
                m_t[k]    <= 0;
            end else begin
                m_t[k]    <= m_t[k] + 1;
                m_idx[k]  <= (m_s[k] + (m_t[k] + 1) / MD[k]) % (1 << MW[k]);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out2",  32'(o2), exp_out(0));
            chk("m_idx2",  32'(i2), 32'(m_idx[0]));
            chk("m_wrap2", 32'(w2), exp_wrap(0));
            chk("m_out3",  32'(o3), exp_out(1));
            chk("m_idx3",  32'(i3), 32'(m_idx[1]));
            chk("m_wrap3", 32'(w3), exp_wrap(1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] scan_out  [10] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000,
                                   4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic       scan_wrap [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        logic [7:0] one;
        one   = 8'd1;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 1'b0;
        din   = 3'd3;
        chk_en = 1'b1;

        tick();
        tick();
        chk("rst_out2",  32'(o2), 32'(pol4(4'b0000)));
        chk("rst_idx2",  32'(i2), 32'd0);
        chk("rst_wrap2", 32'(w2), 32'd0);
        chk("rst_out3",  32'(o3), 32'(pol8(8'h00)));

        rst_n = 1'b1;
        tick();
        chk("rel_out2", 32'(o2), 32'(pol4(4'b1000)));
        chk("rel_idx2", 32'(i2), 32'd3);

        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < 8; i++) begin
                en  = e[0];
                din = 3'(i);
                tick();
                chk("sweep_out3", 32'(o3), 32'(pol8(e[0] ? (one << i) : 8'h00)));
            end
        end

        en   = 1'b1;
        mode = 1'b1;
        din  = 3'd2;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("scan_out2",  32'(o2), 32'(pol4(scan_out[c])));
            chk("scan_wrap2", 32'(w2), 32'(scan_wrap[c]));
        end

        din = 3'd0;
        tick();
        chk("mid_dwell2", 32'(o2), 32'(pol4(4'b0010)));
        en = 1'b0;
        tick();
        chk("pause_out2", 32'(o2), 32'(pol4(4'b0000)));
        chk("pause_idx2", 32'(i2), 32'd1);
        en  = 1'b1;
        din = 3'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("resume_out2", 32'(o2), 32'(pol4(4'b0010)));
        end
        tick();
        chk("resume_adv2", 32'(o2), 32'(pol4(4'b0100)));
        mode = 1'b0;
        din  = 3'd3;
        tick();
        chk("mode_dir2", 32'(o2), 32'(pol4(4'b1000)));
        chk("mode_wrap2", 32'(w2), 32'd0);

        mode = 1'b1;
        din  = 3'd0;
        for (int c = 0; c < 4; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out2", 32'(o2), 32'(pol4(4'b0000)));
        chk("arst_idx2", 32'(i2), 32'd0);
        chk("arst_wrap2", 32'(w2), 32'd0);
        chk("arst_out3", 32'(o3), 32'(pol8(8'h00)));
        chk("arst_idx3", 32'(i3), 32'd0);
        tick();
        rst_n = 1'b1;

        for (int c = 0; c < 60; c++) begin
            en   = ($urandom_range(0, 7) != 0);
            mode = ($urandom_range(0, 3) != 0);
            din  = 3'($urandom_range(0, 7));
            tick();
        end

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
